vend_fsm_multi: RTL and testbench
=================================

Name: vend_fsm_multi

Overview:
Parametrised vending controller that handles NUM_ITEMS products. It keeps per-item stock registers with saturating restock, and supports cancel/refund plus an inactivity auto-refund. It reports coded errors and rejected coins, and returns change in a unified refund/change phase. It sits between the coin-input debouncer/valuer and the dispenser/display logic, and it owns credit and inventory.

Parameters:
NUM_ITEMS, 4, number of selectable products (>=2)
IDX_W, 2, width of item index (>= clog2(NUM_ITEMS))
CREDIT_W, 8, width of credit, coin_value, prices, change_due
STOCK_W, 4, width of each stock counter
INIT_STOCK, 5, reset value of every stock counter (< 2^STOCK_W)
MAX_CREDIT, 15, highest credit the machine will hold
THANK_CYCLES, 100, cycles spent in THANK after a vend (>=1)
IDLE_TIMEOUT, 1000, inactivity cycles before auto-refund; 0 disables

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
coin_pulse  in  1  one-cycle coin-inserted strobe
coin_value  in  CREDIT_W  value of the coin, valid with coin_pulse
purchase_btn  in  1  one-cycle purchase request
cancel_btn  in  1  one-cycle refund request
item_select  in  IDX_W  requested item, sampled with purchase_btn
price_flat  in  NUM_ITEMS*CREDIT_W  item i price in bits [i*CREDIT_W +: CREDIT_W], static
restock_pulse  in  1  one-cycle restock strobe
restock_item  in  IDX_W  item to restock
restock_qty  in  STOCK_W  units to add
credit  out  CREDIT_W  current credit
stock_flat  out  NUM_ITEMS*STOCK_W  all stock counters, same packing as price_flat
state  out  3  0 IDLE, 1 CREDIT, 2 CHECK, 3 VEND, 4 THANK, 5 CHANGE, 6 ERROR
busy  out  1  combinational: state not IDLE/CREDIT
vend_pulse  out  1  one-cycle dispense strobe
vend_item  out  IDX_W  item dispensed, held until the next vend
coin_reject  out  1  one-cycle: coin not accepted
error_flag  out  1  one-cycle on entry to ERROR
error_code  out  3  1 OVERFLOW, 2 SOLD_OUT, 3 INSUFFICIENT, 4 BAD_ITEM; held until the next error
change_valid  out  1  one-cycle: change_due carries nonzero change/refund
change_due  out  CREDIT_W  last returned amount, held

Behaviour:
- Reset (async): credit=0, state=IDLE, every stock=INIT_STOCK; all pulses=0; vend_item=0, error_code=0, change_due=0; idle and thank counters=0; latched selection=0.
- Pulse outputs default to 0 every cycle; registered outputs change one cycle after the causing input.
- IDLE/CREDIT input priority: coin_pulse > cancel_btn > purchase_btn. Lower-priority inputs arriving in the same cycle are dropped.
- Coin acceptance: the sum is computed at CREDIT_W+1 bits.
  - If credit+coin_value > MAX_CREDIT: coin_reject=1, error_code=1, error_flag=1, state->ERROR, credit unchanged.
  - Otherwise credit+=coin_value, state->CREDIT, idle counter cleared.
  - coin_value=0 is accepted as a no-op add.
- cancel_btn: if credit>0, go to CHANGE (refund). If credit=0, ignored.
- purchase_btn: latch item_select as sel, go to CHECK. Allowed with credit=0; CHECK then reports INSUFFICIENT unless the price is 0.
- State between events: CREDIT when credit>0, IDLE when credit=0.
- Idle timeout: in CREDIT with no coin/cancel/purchase, the counter increments each cycle. Any accepted input clears it. When the counter reaches IDLE_TIMEOUT-1, go to CHANGE. Disabled when IDLE_TIMEOUT=0.
- CHECK (1 cycle), checked in order:
  - sel >= NUM_ITEMS -> BAD_ITEM (4)
  - stock[sel]==0 -> SOLD_OUT (2)
  - credit < price[sel] -> INSUFFICIENT (3)
  - any of the above: error_flag=1, state->ERROR
  - otherwise state->VEND
- ERROR (1 cycle): credit retained. Go to CREDIT if credit>0, else IDLE.
- VEND (1 cycle): vend_pulse=1, vend_item=sel, stock[sel]-=1, credit-=price[sel], thank counter=0, state->THANK.
- THANK: exits to CHANGE after exactly THANK_CYCLES cycles in THANK.
- CHANGE (1 cycle): change_due=credit, change_valid=(credit!=0), credit=0, state->IDLE. The same path serves post-vend change, cancel and timeout refunds.
- Coins outside IDLE/CREDIT: coin_reject=1, credit unchanged, no error. cancel_btn and purchase_btn are ignored there.
- Restock: acts in any state. stock[restock_item] = min(stock+restock_qty, 2^STOCK_W-1), saturating. restock_item >= NUM_ITEMS is ignored.
- Restock coinciding with a VEND on the same item: result = sat(stock-1+qty), computed in a single update.
- Reset mid-operation (e.g. during THANK) aborts immediately to reset values. Credit is lost; no change pulse is produced.

Test Plan:
- Coins 5,5 then purchase item 2 (price 7, stock 5). Required: CHECK->VEND; vend_pulse with vend_item=2; stock[2]=4; THANK_CYCLES later, change_valid with change_due=3; credit=0, state IDLE.
- Credit 12, coin 5. Required: coin_reject, error_flag, error_code=1, credit stays 12; next cycle state CREDIT.
- Stock[1]=0, credit 10, purchase item 1. Required: error_code=2, credit 10 retained. Then cancel. Required: change_valid, change_due=10, credit 0.
- Credit 3, purchase item 0 (price 4). Required: error_code=3. Then with no further input for IDLE_TIMEOUT cycles, required: auto-refund with change_due=3.
- Stock[3]=14, restock 5 coincident with VEND of item 3. Required: stock[3]=15 (saturated). Restock item index 7 with NUM_ITEMS=4 is ignored.
- Coin during THANK. Required: coin_reject, credit unchanged. Also cover rst asserted mid-THANK: all outputs at reset values, no vend or change pulse afterwards.

Source files
------------

// File: rtl/vend_fsm_multi.sv
`default_nettype none
// ============================================================================
// vend_fsm_multi : multi-item vending controller owning credit and stock.
// Revision 1.0
// ============================================================================
module vend_fsm_multi #(
   parameter int NUM_ITEMS    = 4,
   parameter int IDX_W        = 2,
   parameter int CREDIT_W     = 8,
   parameter int STOCK_W      = 4,
   parameter int INIT_STOCK   = 5,
   parameter int MAX_CREDIT   = 15,
   parameter int THANK_CYCLES = 100,
   parameter int IDLE_TIMEOUT = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          coin_pulse,
   input  logic [CREDIT_W-1:0]           coin_value,
   input  logic                          purchase_btn,
   input  logic                          cancel_btn,
   input  logic [IDX_W-1:0]              item_select,
   input  logic [NUM_ITEMS*CREDIT_W-1:0] price_flat,
   input  logic                          restock_pulse,
   input  logic [IDX_W-1:0]              restock_item,
   input  logic [STOCK_W-1:0]            restock_qty,
   output logic [CREDIT_W-1:0]           credit,
   output logic [NUM_ITEMS*STOCK_W-1:0]  stock_flat,
   output logic [2:0]                    state,
   output logic                          busy,
   output logic                          vend_pulse,
   output logic [IDX_W-1:0]              vend_item,
   output logic                          coin_reject,
   output logic                          error_flag,
   output logic [2:0]                    error_code,
   output logic                          change_valid,
   output logic [CREDIT_W-1:0]           change_due
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CREDIT = 3'd1,
      S_CHECK  = 3'd2,
      S_VEND   = 3'd3,
      S_THANK  = 3'd4,
      S_CHANGE = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   localparam logic [2:0] c_err_overflow     = 3'd1;
   localparam logic [2:0] c_err_sold_out     = 3'd2;
   localparam logic [2:0] c_err_insufficient = 3'd3;
   localparam logic [2:0] c_err_bad_item     = 3'd4;

   localparam int IDLE_W  = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int THANK_W = (THANK_CYCLES > 1) ? $clog2(THANK_CYCLES) : 1;

   localparam logic [IDLE_W-1:0]   c_idle_last  = IDLE_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
   localparam logic [THANK_W-1:0]  c_thank_last = THANK_W'(THANK_CYCLES - 1);
   localparam logic [CREDIT_W:0]   c_max_credit = (CREDIT_W + 1)'(MAX_CREDIT);
   localparam logic [STOCK_W-1:0]  c_init_stock = STOCK_W'(INIT_STOCK);

   state_t                                 state_q, state_d;
   logic [CREDIT_W-1:0]                    credit_q, credit_d;
   logic [NUM_ITEMS-1:0][STOCK_W-1:0]      stock_q, stock_d;
   logic [IDX_W-1:0]                       sel_q, sel_d;
   logic [IDLE_W-1:0]                      idle_cnt_q, idle_cnt_d;
   logic [THANK_W-1:0]                     thank_cnt_q, thank_cnt_d;
   logic                                   vend_pulse_q, vend_pulse_d;
   logic [IDX_W-1:0]                       vend_item_q, vend_item_d;
   logic                                   coin_reject_q, coin_reject_d;
   logic                                   error_flag_q, error_flag_d;
   logic [2:0]                             error_code_q, error_code_d;
   logic                                   change_valid_q, change_valid_d;
   logic [CREDIT_W-1:0]                    change_due_q, change_due_d;

   logic [NUM_ITEMS-1:0][CREDIT_W-1:0]     price;
   logic [CREDIT_W-1:0]                    price_sel;
   logic [STOCK_W-1:0]                     stock_sel;
   logic                                   sel_valid;
   logic [CREDIT_W:0]                      coin_sum;
   logic                                   accepting;

   assign price     = price_flat;
   assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
   assign accepting = (state_q == S_IDLE) || (state_q == S_CREDIT);

   // Decoded lookup; an out-of-range selection simply never matches.
   always_comb begin
      price_sel = '0;
      stock_sel = '0;
      sel_valid = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (sel_q == IDX_W'(i)) begin
            price_sel = price[i];
            stock_sel = stock_q[i];
            sel_valid = 1'b1;
         end
      end
   end

   // Vend decrement and restock merge into one saturating update per item.
   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_stock
      logic               dec;
      logic [STOCK_W-1:0] add;
      logic [STOCK_W:0]   sum;
      assign dec = (state_q == S_VEND) && (sel_q == IDX_W'(i));
      assign add = (restock_pulse && (restock_item == IDX_W'(i))) ? restock_qty : '0;
      assign sum = {1'b0, stock_q[i]} + {1'b0, add} - {{STOCK_W{1'b0}}, dec};
      assign stock_d[i] = sum[STOCK_W] ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
   end

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      sel_d          = sel_q;
      idle_cnt_d     = '0;
      thank_cnt_d    = thank_cnt_q;
      vend_pulse_d   = 1'b0;
      vend_item_d    = vend_item_q;
      coin_reject_d  = 1'b0;
      error_flag_d   = 1'b0;
      error_code_d   = error_code_q;
      change_valid_d = 1'b0;
      change_due_d   = change_due_q;

      if (coin_pulse && !accepting) begin
         coin_reject_d = 1'b1;
      end

      case (state_q)
         S_IDLE, S_CREDIT: begin
            if (coin_pulse) begin
               if (coin_sum > c_max_credit) begin
                  coin_reject_d = 1'b1;
                  error_flag_d  = 1'b1;
                  error_code_d  = c_err_overflow;
                  state_d       = S_ERROR;
               end else begin
                  credit_d = coin_sum[CREDIT_W-1:0];
                  state_d  = (coin_sum != '0) ? S_CREDIT : S_IDLE;
               end
            end else if (cancel_btn && (credit_q != '0)) begin
               state_d = S_CHANGE;
            end else if (purchase_btn) begin
               sel_d   = item_select;
               state_d = S_CHECK;
            end else if ((state_q == S_CREDIT) && (IDLE_TIMEOUT != 0)) begin
               if (idle_cnt_q == c_idle_last) begin
                  state_d = S_CHANGE;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
               end
            end
         end
         S_CHECK: begin
            state_d = S_ERROR;
            if (!sel_valid) begin
               error_flag_d = 1'b1;
               error_code_d = c_err_bad_item;
            end else if (stock_sel == '0) begin
               error_flag_d = 1'b1;
               error_code_d = c_err_sold_out;
            end else if (credit_q < price_sel) begin
               error_flag_d = 1'b1;
               error_code_d = c_err_insufficient;
            end else begin
               state_d = S_VEND;
            end
         end
         S_VEND: begin
            vend_pulse_d = 1'b1;
            vend_item_d  = sel_q;
            credit_d     = credit_q - price_sel;
            thank_cnt_d  = '0;
            state_d      = S_THANK;
         end
         S_THANK: begin
            if (thank_cnt_q == c_thank_last) begin
               state_d = S_CHANGE;
            end else begin
               thank_cnt_d = thank_cnt_q + 1'b1;
            end
         end
         S_CHANGE: begin
            change_due_d   = credit_q;
            change_valid_d = (credit_q != '0);
            credit_d       = '0;
            state_d        = S_IDLE;
         end
         S_ERROR: begin
            state_d = (credit_q != '0) ? S_CREDIT : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         credit_q       <= '0;
         stock_q        <= {NUM_ITEMS{c_init_stock}};
         sel_q          <= '0;
         idle_cnt_q     <= '0;
         thank_cnt_q    <= '0;
         vend_pulse_q   <= 1'b0;
         vend_item_q    <= '0;
         coin_reject_q  <= 1'b0;
         error_flag_q   <= 1'b0;
         error_code_q   <= '0;
         change_valid_q <= 1'b0;
         change_due_q   <= '0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         stock_q        <= stock_d;
         sel_q          <= sel_d;
         idle_cnt_q     <= idle_cnt_d;
         thank_cnt_q    <= thank_cnt_d;
         vend_pulse_q   <= vend_pulse_d;
         vend_item_q    <= vend_item_d;
         coin_reject_q  <= coin_reject_d;
         error_flag_q   <= error_flag_d;
         error_code_q   <= error_code_d;
         change_valid_q <= change_valid_d;
         change_due_q   <= change_due_d;
      end
   end

   assign credit       = credit_q;
   assign stock_flat   = stock_q;
   assign state        = state_q;
   assign busy         = !accepting;
   assign vend_pulse   = vend_pulse_q;
   assign vend_item    = vend_item_q;
   assign coin_reject  = coin_reject_q;
   assign error_flag   = error_flag_q;
   assign error_code   = error_code_q;
   assign change_valid = change_valid_q;
   assign change_due   = change_due_q;

endmodule
`default_nettype wire

// File: tb/tb_vend_fsm_multi.sv
`default_nettype none
// ============================================================================
// tb_vend_fsm_multi : directed, self-checking bench for vend_fsm_multi.
// Revision 1.0
// ============================================================================
module tb_vend_fsm_multi;

   localparam int NI = 4;
   localparam int IW = 3;
   localparam int CW = 8;
   localparam int SW = 4;
   localparam int TC = 4;
   localparam int IT = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              coin_pulse = 1'b0;
   logic [CW-1:0]     coin_value = '0;
   logic              purchase_btn = 1'b0;
   logic              cancel_btn = 1'b0;
   logic [IW-1:0]     item_select = '0;
   logic [NI*CW-1:0]  price_flat = {8'd2, 8'd7, 8'd3, 8'd4};
   logic              restock_pulse = 1'b0;
   logic [IW-1:0]     restock_item = '0;
   logic [SW-1:0]     restock_qty = '0;
   logic [CW-1:0]     credit;
   logic [NI*SW-1:0]  stock_flat;
   logic [2:0]        state;
   logic              busy;
   logic              vend_pulse;
   logic [IW-1:0]     vend_item;
   logic              coin_reject;
   logic              error_flag;
   logic [2:0]        error_code;
   logic              change_valid;
   logic [CW-1:0]     change_due;

   int n_vec = 0;
   int n_err = 0;

   vend_fsm_multi #(
      .NUM_ITEMS(NI), .IDX_W(IW), .CREDIT_W(CW), .STOCK_W(SW), .INIT_STOCK(5),
      .MAX_CREDIT(15), .THANK_CYCLES(TC), .IDLE_TIMEOUT(IT)
   ) dut (
      .clk(clk), .rst(rst), .coin_pulse(coin_pulse), .coin_value(coin_value),
      .purchase_btn(purchase_btn), .cancel_btn(cancel_btn), .item_select(item_select),
      .price_flat(price_flat), .restock_pulse(restock_pulse), .restock_item(restock_item),
      .restock_qty(restock_qty), .credit(credit), .stock_flat(stock_flat), .state(state),
      .busy(busy), .vend_pulse(vend_pulse), .vend_item(vend_item), .coin_reject(coin_reject),
      .error_flag(error_flag), .error_code(error_code), .change_valid(change_valid),
      .change_due(change_due)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic coin(input logic [CW-1:0] v);
      coin_pulse = 1'b1;
      coin_value = v;
      tick();
      coin_pulse = 1'b0;
      coin_value = '0;
   endtask

   task automatic purchase(input logic [IW-1:0] i);
      purchase_btn = 1'b1;
      item_select  = i;
      tick();
      purchase_btn = 1'b0;
   endtask

   task automatic cancel();
      cancel_btn = 1'b1;
      tick();
      cancel_btn = 1'b0;
   endtask

   task automatic restock(input logic [IW-1:0] i, input logic [SW-1:0] q);
      restock_pulse = 1'b1;
      restock_item  = i;
      restock_qty   = q;
      tick();
      restock_pulse = 1'b0;
   endtask

   initial begin
      // Reset values
      repeat (2) tick();
      chk("rst_credit", credit, 0);
      chk("rst_state", state, 0);
      chk("rst_stock", stock_flat, 16'h5555);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {vend_pulse, coin_reject, error_flag, change_valid}, 0);
      chk("rst_regs", {vend_item, error_code, change_due}, 0);
      rst = 1'b0;
      tick();

      // Normal purchase with change
      coin(8'd5);
      chk("t1_credit5", credit, 5);
      chk("t1_state_credit", state, 1);
      coin(8'd5);
      chk("t1_credit10", credit, 10);
      purchase(3'd2);
      chk("t1_check", state, 2);
      chk("t1_busy", busy, 1);
      tick();
      chk("t1_vend_state", state, 3);
      tick();
      chk("t1_thank", state, 4);
      chk("t1_vend_pulse", vend_pulse, 1);
      chk("t1_vend_item", vend_item, 2);
      chk("t1_stock", stock_flat, 16'h5455);
      chk("t1_credit_left", credit, 3);
      repeat (TC - 1) tick();
      chk("t1_thank_last", state, 4);
      chk("t1_vend_one_cycle", vend_pulse, 0);
      tick();
      chk("t1_change_state", state, 5);
      tick();
      chk("t1_change_valid", change_valid, 1);
      chk("t1_change_due", change_due, 3);
      chk("t1_credit0", credit, 0);
      chk("t1_idle", state, 0);
      tick();
      chk("t1_change_one_cycle", change_valid, 0);

      // Overflow rejection
      coin(8'd5);
      coin(8'd5);
      coin(8'd2);
      chk("t2_credit12", credit, 12);
      coin(8'd5);
      chk("t2_reject", coin_reject, 1);
      chk("t2_eflag", error_flag, 1);
      chk("t2_ecode", error_code, 1);
      chk("t2_credit_kept", credit, 12);
      chk("t2_error_state", state, 6);
      tick();
      chk("t2_back_credit", state, 1);
      chk("t2_ecode_held", error_code, 1);
      chk("t2_pulses_clear", {coin_reject, error_flag}, 0);
      cancel();
      tick();
      chk("t2_refund", change_due, 12);

      // Drain item 1 with exact money, then sold-out
      for (int k = 0; k < 5; k++) begin
         coin(8'd3);
         purchase(3'd1);
         repeat (TC + 3) tick();
      end
      chk("t3_exact_no_change", change_valid, 0);
      chk("t3_exact_due0", change_due, 0);
      chk("t3_stock_drained", stock_flat, 16'h5405);
      coin(8'd5);
      coin(8'd5);
      purchase(3'd1);
      tick();
      chk("t3_soldout_flag", error_flag, 1);
      chk("t3_soldout_code", error_code, 2);
      chk("t3_credit_kept", credit, 10);
      tick();
      chk("t3_back_credit", state, 1);
      cancel();
      tick();
      chk("t3_cancel_valid", change_valid, 1);
      chk("t3_cancel_due", change_due, 10);
      chk("t3_cancel_credit0", credit, 0);

      // Insufficient then idle-timeout refund
      coin(8'd3);
      purchase(3'd0);
      tick();
      chk("t4_insuff_code", error_code, 3);
      chk("t4_insuff_flag", error_flag, 1);
      tick();
      chk("t4_credit_state", state, 1);
      repeat (IT - 1) tick();
      chk("t4_before_timeout", state, 1);
      tick();
      chk("t4_timeout_change", state, 5);
      tick();
      chk("t4_refund_valid", change_valid, 1);
      chk("t4_refund_due", change_due, 3);
      chk("t4_refund_credit0", credit, 0);

      // Bad item index with zero credit
      purchase(3'd5);
      tick();
      chk("t4b_bad_item", error_code, 4);
      tick();
      chk("t4b_idle", state, 0);

      // Coin beats purchase in the same cycle
      coin_pulse = 1'b1;
      coin_value = 8'd2;
      purchase(3'd0);
      coin_pulse = 1'b0;
      coin_value = '0;
      chk("t4c_prio_state", state, 1);
      chk("t4c_prio_credit", credit, 2);
      cancel();
      tick();
      chk("t4c_refund", change_due, 2);

      // Restock saturating, coincident with vend
      restock(3'd3, 4'd9);
      chk("t5_restock14", stock_flat, 16'hE405);
      coin(8'd5);
      purchase(3'd3);
      tick();
      chk("t5_vend_state", state, 3);
      restock(3'd3, 4'd5);
      chk("t5_sat_merge", stock_flat, 16'hF405);
      chk("t5_vend_item", vend_item, 3);
      restock(3'd7, 4'd3);
      chk("t5_bad_restock", stock_flat, 16'hF405);
      restock(3'd0, 4'd15);
      chk("t5_restock_sat", stock_flat, 16'hF40F);

      // Coin during THANK, then reset mid-THANK
      coin(8'd5);
      chk("t6_thank_reject", coin_reject, 1);
      chk("t6_thank_credit", credit, 3);
      chk("t6_thank_noerr", error_flag, 0);
      chk("t6_thank_state", state, 4);
      rst = 1'b1;
      #1;
      chk("t6_rst_state", state, 0);
      chk("t6_rst_credit", credit, 0);
      chk("t6_rst_stock", stock_flat, 16'h5555);
      chk("t6_rst_regs", {vend_item, error_code, change_due}, 0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("t6_no_pulse", {vend_pulse, change_valid, state}, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
